memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 115 +++++++++++
 tb/tb_memory_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed memory responder. Writes complete in one cycle; reads return
// rdata with a one-cycle rdata_ack pulse READ_LATENCY cycles after acceptance.
module memory_responder #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  output logic [31:0] rdata,
  output logic        rdata_ack,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // WAIT spends READ_LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [3:0]  WAIT_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
  localparam logic [31:0] OOR_DATA  = 32'hDEAD_BEEF;

  // Handshake: a request is taken on any rising edge where req_valid=1 and
  // the FSM is IDLE; in WAIT/ACK req_valid is ignored, so a master holding a
  // read past its ack gets it accepted again in the next IDLE cycle.

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [31:0]   pend_data;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic          do_write;
  logic          do_read;
  logic [31:0]   read_word;
  logic [1:0]    unused_addr_bits;

  assign word_idx         = req_addr[AW+1:2];
  assign in_range         = (req_addr[31:AW+2] == '0);
  assign accept           = (state == S_IDLE) && req_valid;
  assign do_write         = accept && req_write;
  assign do_read          = accept && !req_write;
  assign read_word        = in_range ? mem[word_idx] : OOR_DATA;
  assign unused_addr_bits = req_addr[1:0];

  assign rdata_ack = (state == S_ACK);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      pend_data <= 32'd0;
      rdata     <= 32'd0;
      rd_count  <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_read) begin
            // Data is captured at acceptance so the read sees a same-edge-prior write.
            pend_data <= read_word;
            wait_cnt  <= WAIT_LOAD;
            if (READ_LATENCY == 1) begin
              state <= S_ACK;
              rdata <= read_word;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_ACK;
            rdata <= pend_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= 16'd0;
    end else if (do_write && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Out-of-range writes are counted above but never reach the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (do_write && in_range) begin
      mem[word_idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (latency 1, 2, 4) share one
// stimulus stream and are compared every cycle against a timestamp-based model.
module tb_memory_responder;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int N     = 3;
  localparam int LATS [N] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic [31:0] rdata     [N];
  logic        rdata_ack [N];
  logic        busy      [N];
  logic [15:0] wr_count  [N];
  logic [15:0] rd_count  [N];
  logic [1:0]  state_dbg [N];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .rdata(rdata[0]),
    .rdata_ack(rdata_ack[0]), .busy(busy[0]), .wr_count(wr_count[0]),
    .rd_count(rd_count[0]), .state_dbg(state_dbg[0]));

  memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .rdata(rdata[1]),
    .rdata_ack(rdata_ack[1]), .busy(busy[1]), .wr_count(wr_count[1]),
    .rd_count(rd_count[1]), .state_dbg(state_dbg[1]));

  memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .rdata(rdata[2]),
    .rdata_ack(rdata_ack[2]), .busy(busy[2]), .wr_count(wr_count[2]),
    .rd_count(rd_count[2]), .state_dbg(state_dbg[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pending read is just (ack edge, data); everything else
  // follows from comparing the current edge number against that timestamp.
  logic [31:0] m_mem   [N][DEPTH];
  bit          m_pend  [N];
  int          m_ack_edge [N];
  logic [31:0] m_pdata [N];
  logic [31:0] m_rdata [N];
  bit          m_ack   [N];
  int          m_wr    [N];
  int          m_rd    [N];
  int          edge_k;

  task automatic model_clear();
    edge_k = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_ack_edge[i] = -10; m_pdata[i] = 32'd0;
      m_rdata[i] = 32'd0; m_ack[i] = 1'b0; m_wr[i] = 0; m_rd[i] = 0;
      for (int j = 0; j < DEPTH; j++) m_mem[i][j] = 32'd0;
    end
  endtask

  task automatic model_step();
    int  idx;
    bit  inr;
    edge_k++;
    idx = int'((req_addr >> 2) % DEPTH);
    inr = ((req_addr >> (AW + 2)) == 32'd0);
    for (int i = 0; i < N; i++) begin
      if (!m_pend[i]) begin
        if (req_valid && req_write) begin
          if (m_wr[i] < 65535) m_wr[i]++;
          if (inr) m_mem[i][idx] = req_wdata;
        end else if (req_valid) begin
          m_pend[i]     = 1'b1;
          m_pdata[i]    = inr ? m_mem[i][idx] : 32'hDEAD_BEEF;
          m_ack_edge[i] = edge_k + LATS[i] - 1;
        end
      end else if (edge_k == m_ack_edge[i] + 1) begin
        if (m_rd[i] < 65535) m_rd[i]++;
        m_pend[i] = 1'b0;
      end
      m_ack[i] = m_pend[i] && (edge_k == m_ack_edge[i]);
      if (m_ack[i]) m_rdata[i] = m_pdata[i];
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("lat%0d rdata", LATS[i]), rdata[i], m_rdata[i]);
          chk($sformatf("lat%0d rdata_ack", LATS[i]), 32'(rdata_ack[i]), 32'(m_ack[i]));
          chk($sformatf("lat%0d busy", LATS[i]), 32'(busy[i]), 32'(m_pend[i]));
          chk($sformatf("lat%0d wr_count", LATS[i]), 32'(wr_count[i]), 32'(m_wr[i]));
          chk($sformatf("lat%0d rd_count", LATS[i]), 32'(rd_count[i]), 32'(m_rd[i]));
        end
      end
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (!(m_pend[0] || m_pend[1] || m_pend[2])) return;
      next_cycle();
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: reads still pending after 40 cycles");
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    next_cycle();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Issues one read to all instances and pins latency, pulse width, busy span
  // and returned data with literal expectations.
  task automatic measure_read(input logic [31:0] a, input logic [31:0] exp_data);
    int lat_seen [N];
    int ack_n    [N];
    int busy_n   [N];
    wait_idle();
    for (int i = 0; i < N; i++) begin lat_seen[i] = 0; ack_n[i] = 0; busy_n[i] = 0; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rdata_ack[i]) begin
          ack_n[i]++;
          if (lat_seen[i] == 0) lat_seen[i] = n;
          chk($sformatf("lat%0d read data @%h", LATS[i], a), rdata[i], exp_data);
        end
        if (busy[i]) busy_n[i]++;
      end
      #1;
      req_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("lat%0d ack latency", LATS[i]), 32'(lat_seen[i]), 32'(LATS[i]));
      chk($sformatf("lat%0d ack pulses", LATS[i]), 32'(ack_n[i]), 32'd1);
      chk($sformatf("lat%0d busy cycles", LATS[i]), 32'(busy_n[i]), 32'(LATS[i]));
    end
  endtask

  task automatic chk_counts(input logic [15:0] wr, input logic [15:0] rd);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("lat%0d wr_count literal", LATS[i]), 32'(wr_count[i]), 32'(wr));
      chk($sformatf("lat%0d rd_count literal", LATS[i]), 32'(rd_count[i]), 32'(rd));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s lat%0d rdata", tag, LATS[i]), rdata[i], 32'd0);
      chk($sformatf("%s lat%0d rdata_ack", tag, LATS[i]), 32'(rdata_ack[i]), 32'd0);
      chk($sformatf("%s lat%0d busy", tag, LATS[i]), 32'(busy[i]), 32'd0);
    end
    chk_counts(16'd0, 16'd0);
  endtask

  initial begin
    int acks;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk_en = 1'b1;
    #1 reset = 1'b0;

    // First request straight after reset release, then read it back.
    issue_write(32'h10, 32'hA5A5_0001);
    measure_read(32'h10, 32'hA5A5_0001);
    wait_idle();
    chk_counts(16'd1, 16'd1);

    // Write presented while busy (WAIT, or ACK for latency 1) is dropped.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    next_cycle();
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    next_cycle();
    req_valid = 1'b0; req_write = 1'b0;
    wait_idle();
    chk_counts(16'd1, 16'd2);
    measure_read(32'h20, 32'd0);

    // Out-of-range read and write, then word 0 must still be untouched.
    measure_read(32'h0000_1000, 32'hDEAD_BEEF);
    issue_write(32'h0000_1000, 32'hCAFE_F00D);
    wait_idle();
    chk_counts(16'd2, 16'd4);
    measure_read(32'h0, 32'd0);

    // Back-to-back write then read of the same word; low address bits ignored.
    issue_write(32'h44, 32'h5555_AAAA);
    measure_read(32'h47, 32'h5555_AAAA);

    // Randomized traffic, checked each cycle by the model.
    for (int c = 0; c < 800; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      case ($urandom_range(0, 7))
        0: req_addr = 32'h1000 | (32'($urandom_range(0, 63)) << 2);
        1: req_addr = $urandom;
        default: req_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      endcase
      next_cycle();
    end
    req_valid = 1'b0;
    wait_idle();

    // Reset while reads are in flight (latency 2 in ACK, latency 4 in WAIT).
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    repeat (2) next_cycle();
    reset = 1'b0;
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (rdata_ack[i]) acks++;
    end
    #1;
    chk("ack after aborted read", 32'(acks), 32'd0);
    measure_read(32'h44, 32'd0);
    wait_idle();

    // Write counter saturation.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h0BAD_F00D;
    repeat (65534) @(negedge clk);
    chk_counts(16'hFFFE, 16'd1);
    repeat (3) @(negedge clk);
    chk_counts(16'hFFFF, 16'd1);
    #1 req_valid = 1'b0; req_write = 1'b0;
    measure_read(32'h8, 32'h0BAD_F00D);

    next_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
